// File: rtl/writeback_buffer.sv
// Write-back FIFO in front of the register file write port.
// Drains one entry per cycle and forwards the newest pending data per operand.
module writeback_buffer #(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        InValid,
  output logic        InReady,
  input  logic [4:0]  InRegAddress,
  input  logic [31:0] InData,
  input  logic        HoldWrite,
  output logic        WriteControl,
  output logic [4:0]  WriteRegAddress,
  output logic [31:0] DataOfWrite,
  input  logic [4:0]  ReadReg1Address,
  input  logic [4:0]  ReadReg2Address,
  output logic        PendingHit1,
  output logic        PendingHit2,
  output logic [31:0] ForwardData1,
  output logic [31:0] ForwardData2,
  output logic        Empty
);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_entry_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  wb_entry_t     mem_q [DEPTH];
  wb_entry_t     mem_d [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic          wc_q, wc_d;
  logic [4:0]    wa_q, wa_d;
  logic [31:0]   wd_q, wd_d;
  logic          accept, drain;
  logic [AW-1:0] idx;

  assign InReady         = (count_q != FULL);
  assign WriteControl    = wc_q;
  assign WriteRegAddress = wa_q;
  assign DataOfWrite     = wd_q;
  assign Empty           = (count_q == '0) & ~wc_q;

  always_comb begin
    // r0 writes are swallowed: they handshake but never occupy a slot
    accept  = InValid & InReady & (InRegAddress != 5'd0);
    drain   = (count_q != '0) & ~HoldWrite;
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    wc_d    = drain;
    wa_d    = wa_q;
    wd_d    = wd_q;
    if (drain) begin
      wa_d   = mem_q[head_q].addr;
      wd_d   = mem_q[head_q].data;
      head_d = head_q + 1'b1;
    end
    if (accept) begin
      mem_d[tail_q] = '{addr: InRegAddress, data: InData};
      tail_d        = tail_q + 1'b1;
    end
    case ({accept, drain})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Scan oldest to youngest so the last match wins; output register is oldest of all
  always_comb begin
    PendingHit1  = wc_q & (ReadReg1Address != 5'd0) & (wa_q == ReadReg1Address);
    PendingHit2  = wc_q & (ReadReg2Address != 5'd0) & (wa_q == ReadReg2Address);
    ForwardData1 = PendingHit1 ? wd_q : 32'd0;
    ForwardData2 = PendingHit2 ? wd_q : 32'd0;
    idx          = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + AW'(i);
      if ((AW+1)'(i) < count_q) begin
        if (ReadReg1Address != 5'd0 && mem_q[idx].addr == ReadReg1Address) begin
          PendingHit1  = 1'b1;
          ForwardData1 = mem_q[idx].data;
        end
        if (ReadReg2Address != 5'd0 && mem_q[idx].addr == ReadReg2Address) begin
          PendingHit2  = 1'b1;
          ForwardData2 = mem_q[idx].data;
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      wc_q    <= 1'b0;
      wa_q    <= 5'd0;
      wd_q    <= 32'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      wc_q    <= wc_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q alone
  always_ff @(posedge Clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_writeback_buffer.sv
// Bench for writeback_buffer: queue-based reference model checked every cycle,
// plus directed literal expectations.
module tb_writeback_buffer;
  localparam int DEPTH = 2;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [4:0]  InRegAddress = 5'd0;
  logic [31:0] InData = 32'd0;
  logic        HoldWrite = 1'b0;
  logic        WriteControl;
  logic [4:0]  WriteRegAddress;
  logic [31:0] DataOfWrite;
  logic [4:0]  ReadReg1Address = 5'd0;
  logic [4:0]  ReadReg2Address = 5'd0;
  logic        PendingHit1, PendingHit2;
  logic [31:0] ForwardData1, ForwardData2;
  logic        Empty;

  writeback_buffer #(.DEPTH(DEPTH), .AW(1)) dut (
    .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .InRegAddress(InRegAddress), .InData(InData), .HoldWrite(HoldWrite),
    .WriteControl(WriteControl), .WriteRegAddress(WriteRegAddress),
    .DataOfWrite(DataOfWrite), .ReadReg1Address(ReadReg1Address),
    .ReadReg2Address(ReadReg2Address), .PendingHit1(PendingHit1),
    .PendingHit2(PendingHit2), .ForwardData1(ForwardData1),
    .ForwardData2(ForwardData2), .Empty(Empty)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of pending writes plus the write-port register
  typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
  ent_t        q[$];
  bit          m_wc = 0;
  logic [4:0]  m_wa = 0;
  logic [31:0] m_wd = 0;
  int          max_cnt = 0;

  always @(posedge Clock) begin
    if (!Reset) begin
      q.delete();
      m_wc = 0; m_wa = 0; m_wd = 0;
    end else begin
      bit rdy, drn;
      ent_t e;
      rdy = (q.size() != DEPTH);
      drn = (q.size() != 0) && !HoldWrite;
      m_wc = drn;
      if (drn) begin
        e = q.pop_front();
        m_wa = e.a; m_wd = e.d;
      end
      if (InValid && rdy && InRegAddress != 0) begin
        e.a = InRegAddress; e.d = InData;
        q.push_back(e);
      end
      if (q.size() > max_cnt) max_cnt = q.size();
    end
  end

  function automatic logic [32:0] lookup(input logic [4:0] ra);
    if (ra == 0) return 33'd0;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].a == ra) return {1'b1, q[i].d};
    if (m_wc && m_wa == ra) return {1'b1, m_wd};
    return 33'd0;
  endfunction

  always @(negedge Clock) begin
    if (chk_en) begin
      logic [32:0] f1, f2;
      f1 = lookup(ReadReg1Address);
      f2 = lookup(ReadReg2Address);
      check("InReady",      {31'd0, InReady},      {31'd0, q.size() != DEPTH});
      check("WriteControl", {31'd0, WriteControl}, {31'd0, m_wc});
      check("WriteRegAddr", {27'd0, WriteRegAddress}, {27'd0, m_wa});
      check("DataOfWrite",  DataOfWrite,  m_wd);
      check("Empty",        {31'd0, Empty}, {31'd0, (q.size() == 0) && !m_wc});
      check("PendingHit1",  {31'd0, PendingHit1}, {31'd0, f1[32]});
      check("PendingHit2",  {31'd0, PendingHit2}, {31'd0, f2[32]});
      check("ForwardData1", ForwardData1, f1[31:0]);
      check("ForwardData2", ForwardData2, f2[31:0]);
    end
  end

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  initial begin
    // 1: reset
    tick; chk_en = 1'b1;
    tick;
    check("rst_wc",    {31'd0, WriteControl}, 32'd0);
    check("rst_empty", {31'd0, Empty}, 32'd1);
    check("rst_ready", {31'd0, InReady}, 32'd1);
    check("rst_hit",   {30'd0, PendingHit1, PendingHit2}, 32'd0);
    Reset = 1'b1;
    tick;

    // 2: single write, two-edge latency
    InValid = 1; InRegAddress = 5; InData = 32'h1234_5678;
    tick;
    InValid = 0;
    check("t2_wc_early", {31'd0, WriteControl}, 32'd0);
    tick;
    check("t2_wc",   {31'd0, WriteControl}, 32'd1);
    check("t2_addr", {27'd0, WriteRegAddress}, 32'd5);
    check("t2_data", DataOfWrite, 32'h1234_5678);
    tick;
    check("t2_wc_off", {31'd0, WriteControl}, 32'd0);
    check("t2_empty",  {31'd0, Empty}, 32'd1);

    // 3: hold, fill, forward youngest, then ordered drain
    HoldWrite = 1; InValid = 1; InRegAddress = 3; InData = 32'hA;
    tick;
    check("t3_ready1", {31'd0, InReady}, 32'd1);
    InData = 32'hB;
    tick;
    check("t3_full", {31'd0, InReady}, 32'd0);
    InValid = 0; ReadReg1Address = 3; ReadReg2Address = 5;
    #1;
    check("t3_hit1", {31'd0, PendingHit1}, 32'd1);
    check("t3_fwd1", ForwardData1, 32'hB);
    check("t3_hit2", {31'd0, PendingHit2}, 32'd0);
    HoldWrite = 0;
    tick;
    check("t3_w1", DataOfWrite, 32'hA);
    check("t3_fwd_mid", ForwardData1, 32'hB);
    tick;
    check("t3_w2", DataOfWrite, 32'hB);
    check("t3_wc2", {31'd0, WriteControl}, 32'd1);
    tick;
    check("t3_empty", {31'd0, Empty}, 32'd1);

    // 4: r0 is discarded
    InValid = 1; InRegAddress = 0; InData = 32'hFFFF_FFFF; ReadReg1Address = 0;
    tick;
    InValid = 0;
    check("t4_ready", {31'd0, InReady}, 32'd1);
    check("t4_empty", {31'd0, Empty}, 32'd1);
    check("t4_hit",   {31'd0, PendingHit1}, 32'd0);
    tick;
    check("t4_wc", {31'd0, WriteControl}, 32'd0);

    // 5: streaming with pointer wrap
    max_cnt = 0; ReadReg1Address = 1; ReadReg2Address = 2;
    for (int i = 0; i < 10; i++) begin
      InValid = 1; InRegAddress = (i % 2) ? 5'd2 : 5'd1; InData = 32'h100 + i;
      tick;
      check("t5_ready", {31'd0, InReady}, 32'd1);
      if (i > 0) begin
        check("t5_wc",   {31'd0, WriteControl}, 32'd1);
        check("t5_data", DataOfWrite, 32'h100 + i - 1);
      end
    end
    InValid = 0;
    tick;
    check("t5_last_data", DataOfWrite, 32'h109);
    check("t5_last_addr", {27'd0, WriteRegAddress}, 32'd2);
    check("t5_maxcnt", max_cnt, 32'd1);
    tick;
    check("t5_empty", {31'd0, Empty}, 32'd1);

    // 6: reset mid-drain drops queued entries
    HoldWrite = 1; InValid = 1; InRegAddress = 7; InData = 32'h77;
    tick;
    InRegAddress = 8; InData = 32'h88;
    tick;
    InValid = 0;
    check("t6_full", {31'd0, InReady}, 32'd0);
    HoldWrite = 0;
    tick;
    check("t6_drain", DataOfWrite, 32'h77);
    Reset = 0;
    tick;
    check("t6_wc",    {31'd0, WriteControl}, 32'd0);
    check("t6_empty", {31'd0, Empty}, 32'd1);
    check("t6_ready", {31'd0, InReady}, 32'd1);
    check("t6_addr",  {27'd0, WriteRegAddress}, 32'd0);
    Reset = 1;
    tick;
    check("t6_nowr1", {31'd0, WriteControl}, 32'd0);
    tick;
    check("t6_nowr2", {31'd0, WriteControl}, 32'd0);
    tick;
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
